// File: rtl/instruction_queue.sv
// instruction_queue
// -----------------------------------------------------------------------------
// Decoupling FIFO between fetch and decode. Each entry carries an instruction
// word, its PC and the fetch-time branch prediction. Fetch pushes at the tail,
// decode pops the head through a valid/ready handshake, and a flush empties
// the queue in a single cycle.
//
// Optional feature macro: INSTRUCTION_QUEUE_BYPASS_EN
//   When defined, an entry offered to an empty queue is presented on deq_*
//   in the same cycle. If decode accepts it, it is never written into storage.
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset (pointers only)
//   flush           discard all entries, highest priority
//   enq_valid/ready fetch-side handshake (ready = not full, state only)
//   enq_pc/insn/pred_taken/pred_target   entry payload from fetch
//   deq_valid/ready decode-side handshake (valid = not empty)
//   deq_pc/insn/pred_taken/pred_target   head payload, zero when not valid
//   count           number of occupied entries
// -----------------------------------------------------------------------------
module instruction_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [ADDR_WIDTH-1:0]   enq_pc,
  input  logic [INSN_WIDTH-1:0]   enq_insn,
  input  logic                    enq_pred_taken,
  input  logic [ADDR_WIDTH-1:0]   enq_pred_target,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [ADDR_WIDTH-1:0]   deq_pc,
  output logic [INSN_WIDTH-1:0]   deq_insn,
  output logic                    deq_pred_taken,
  output logic [ADDR_WIDTH-1:0]   deq_pred_target,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [ADDR_WIDTH-1:0] r_pc_mem     [DEPTH];
  logic [INSN_WIDTH-1:0] r_insn_mem   [DEPTH];
  logic                  r_taken_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] r_target_mem [DEPTH];

  logic [IDX_W-1:0]      w_head_idx;
  logic [IDX_W-1:0]      w_tail_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_enq_fire;
  logic                  w_deq_fire;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
  logic                  w_bypass;
`endif

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  // Extra pointer MSB distinguishes full (wrap bits differ) from empty.
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[PTR_W-1] != r_tail[PTR_W-1]);

  assign enq_ready  = !w_full;
  assign count      = r_tail - r_head;

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
  assign w_bypass   = w_empty && !flush && enq_valid;
`endif

  // Handshake firing; flush cancels both sides for this cycle.
  always_comb begin
    w_enq_fire = 1'b0;
    w_deq_fire = 1'b0;
    if (!flush) begin
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
      // A bypassed entry that decode accepts never touches storage.
      w_enq_fire = enq_valid && !w_full && !(w_bypass && deq_ready);
`else
      w_enq_fire = enq_valid && !w_full;
`endif
      // Only stored entries move the head pointer.
      w_deq_fire = !w_empty && deq_ready;
    end else begin
      w_enq_fire = 1'b0;
      w_deq_fire = 1'b0;
    end
  end

  // Head output mux; payload is forced to zero when no entry is presented.
  always_comb begin
    deq_valid       = 1'b0;
    deq_pc          = {ADDR_WIDTH{1'b0}};
    deq_insn        = {INSN_WIDTH{1'b0}};
    deq_pred_taken  = 1'b0;
    deq_pred_target = {ADDR_WIDTH{1'b0}};
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
    if (w_bypass) begin
      deq_valid       = 1'b1;
      deq_pc          = enq_pc;
      deq_insn        = enq_insn;
      deq_pred_taken  = enq_pred_taken;
      deq_pred_target = enq_pred_target;
    end else if (!w_empty) begin
`else
    if (!w_empty) begin
`endif
      deq_valid       = 1'b1;
      deq_pc          = r_pc_mem[w_head_idx];
      deq_insn        = r_insn_mem[w_head_idx];
      deq_pred_taken  = r_taken_mem[w_head_idx];
      deq_pred_target = r_target_mem[w_head_idx];
    end else begin
      deq_valid       = 1'b0;
    end
  end

  // Pointer registers; reset and flush both collapse the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head <= {PTR_W{1'b0}};
      r_tail <= {PTR_W{1'b0}};
    end else begin
      if (w_enq_fire) begin
        r_tail <= r_tail + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (w_deq_fire) begin
        r_head <= r_head + {{(PTR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; intentionally not reset, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_pc_mem[w_tail_idx]     <= enq_pc;
      r_insn_mem[w_tail_idx]   <= enq_insn;
      r_taken_mem[w_tail_idx]  <= enq_pred_taken;
      r_target_mem[w_tail_idx] <= enq_pred_target;
    end
  end

endmodule
